// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter: buffers CPU stores and paces one
// uart_wr_o strobe every BYTE_CYCLES clocks so the transmitter is never hit while busy.
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int BYTE_CYCLES = 6720
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rstn_i,
  input  logic                     wr_en_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     clr_ovf_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     uart_wr_o,
  output logic [7:0]               uart_dat_o
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int PACE_W = $clog2(BYTE_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [PACE_W-1:0] pace;
  logic              full;
  logic              push;
  logic              drop;
  logic              pop;

  assign full = (count == CW'(DEPTH));
  assign push = wr_en_i && !full;
  assign drop = wr_en_i && full;
  assign pop  = (state == IDLE) && (count != '0);

  assign full_o  = full;
  assign empty_o = (count == '0);
  assign count_o = count;

  // NOTE: storage is deliberately left out of reset; count and pointers alone
  // define which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block
  // sees the pre-edge values of count, state and pointers.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop on the same edge as a clear keeps the flag set.
      if (drop)           overflow_o <= 1'b1;
      else if (clr_ovf_i) overflow_o <= 1'b0;
    end
  end

  // Strobe-to-strobe spacing: IDLE(1) + ISSUE(1) + WAIT(BYTE_CYCLES-2 incl. the 0 cycle).
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state      <= IDLE;
      pace       <= '0;
      uart_wr_o  <= 1'b0;
      uart_dat_o <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            uart_dat_o <= mem[rd_ptr];
            uart_wr_o  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          uart_wr_o <= 1'b0;
          pace      <= PACE_W'(BYTE_CYCLES - 3);
          state     <= WAIT;
        end
        WAIT: begin
          if (pace == '0) state <= IDLE;
          else            pace  <= pace - PACE_W'(1);
        end
        default: begin
          uart_wr_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo against a queue-based model
// that emits a byte whenever one is queued and BYTE_CYCLES edges have passed since the last.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int B     = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          uart_wr;
  logic [7:0]    uart_dat;

  uart_tx_fifo #(.DEPTH(DEPTH), .BYTE_CYCLES(B)) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rstn),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .clr_ovf_i  (clr_ovf),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .overflow_o (overflow),
    .uart_wr_o  (uart_wr),
    .uart_dat_o (uart_dat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] exp_dat = 8'h00;
  logic       exp_ovf = 1'b0;
  int         cyc     = 0;
  int         next_ok = 0;
  int         strobes = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
  endtask

  task automatic check_outputs(input logic exp_wr);
    check("uart_wr",  32'(uart_wr),  32'(exp_wr));
    check("uart_dat", 32'(uart_dat), 32'(exp_dat));
    check("count",    32'(count),    32'(q.size()));
    check("full",     32'(full),     32'(q.size() == DEPTH));
    check("empty",    32'(empty),    32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge,
  // compare 1 time unit later.
  task automatic step(input logic wr, input logic [7:0] d, input logic clr);
    logic exp_wr;
    logic drop;
    @(negedge clk);
    wr_en = wr; wr_data = d; clr_ovf = clr;
    @(posedge clk);
    exp_wr = 1'b0;
    drop   = wr && (q.size() == DEPTH);
    if (q.size() > 0 && cyc >= next_ok) begin
      exp_wr  = 1'b1;
      exp_dat = q.pop_front();
      next_ok = cyc + B;
      strobes++;
    end
    if (wr && !drop) q.push_back(d);
    if (drop)     exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    cyc++;
    #1;
    check_outputs(exp_wr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1 rstn = 1'b0;
    wr_en = 1'b0; clr_ovf = 1'b0;
    q.delete();
    exp_dat = 8'h00;
    exp_ovf = 1'b0;
    next_ok = 0;
    #1;
    check_outputs(1'b0);
    repeat (2) @(posedge clk);
    #1 check_outputs(1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int s0;
    // Reset state
    apply_reset();

    // Single byte: strobe one edge after the push edge
    step(1'b1, 8'h41, 1'b0);
    s0 = strobes;
    step(1'b0, 8'h00, 1'b0);
    check("single_strobe", 32'(strobes - s0), 32'd1);
    idle(B + 2);

    // Burst 01..05 back-to-back, spacing enforced by the model
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0);
    idle(6 * B);

    // Overflow while stalled in WAIT: DEPTH+1 pushes, last one dropped
    step(1'b1, 8'hA0, 1'b0);
    idle(3);
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 8'(8'hB0 + i), 1'b0);
    check("ovf_full",  32'(full),     32'd1);
    check("ovf_count", 32'(count),    32'(DEPTH));
    check("ovf_flag",  32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("ovf_clear", 32'(overflow), 32'd0);

    // Keep pushing while full so the push on the pop edge is dropped
    for (int i = 0; i < B + 2; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    idle(DEPTH * B + 4);

    // Wrap: 3*DEPTH distinct bytes, never overfilling
    for (int i = 0; i < 3 * DEPTH; i++) begin
      for (int w = 0; w < 4 * B && q.size() == DEPTH; w++) step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'(8'h80 + i), 1'b0);
    end
    idle(DEPTH * B + 4);
    check("wrap_drained", 32'(empty), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 15) == 0));
    idle(DEPTH * B + 4);

    // Reset mid-WAIT with 3 bytes queued
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h61 + i), 1'b0);
    idle(2);
    check("pre_rst_q", 32'(count), 32'd3);
    apply_reset();
    s0 = strobes;
    idle(2);
    check("post_rst_quiet", 32'(uart_wr), 32'd0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("post_rst_lat", 32'(strobes - s0), 32'd1);
    idle(B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
